// File: rtl/msg_deconverter_rx_if.sv
// Link-side bundle of the message deconverter: encoded serial input, decoded bit,
// and the word output buffer with its valid/ready handshake.
interface msg_deconverter_rx_if #(
    parameter int DATA_W = 8
);
    logic              z_i;
    logic              z_valid_i;
    logic              x_o;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic              data_ready_i;
    logic              overflow_o;

    modport master (
        output z_i, z_valid_i, data_ready_i,
        input  x_o, data_o, data_valid_o, overflow_o
    );

    modport slave (
        input  z_i, z_valid_i, data_ready_i,
        output x_o, data_o, data_valid_o, overflow_o
    );
endinterface

// File: rtl/msg_deconverter_rx.sv
// Inverse of the Mealy message converter: decodes x = z ^ s from the serial stream,
// deserialises x LSB-first into DATA_W-bit words and holds them in a one-word buffer.
module msg_deconverter_rx #(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    msg_deconverter_rx_if.slave  bus
);
    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state_reg, state_next;
    logic              x_bit;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_in;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              data_valid_reg, data_valid_next;
    logic              overflow_reg, overflow_next;
    logic              word_done;
    logic              load_word;

    // Decoder FSM: state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= S_EVEN;
        end else if (clr_i) begin
            state_reg <= S_EVEN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Decoder FSM: s flips whenever the decoded bit is 0, mirroring the encoder
    always_comb begin
        state_next = state_reg;
        if (bus.z_valid_i && !x_bit) begin
            state_next = (state_reg == S_EVEN) ? S_ODD : S_EVEN;
        end
    end

    // Decoder FSM: Mealy output
    always_comb begin
        x_bit = bus.z_i ^ (state_reg == S_ODD);
    end

    assign bus.x_o = x_bit;

    // New bit enters at the MSB so the first bit of a word ends up at bit 0
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W - 1; gi++) begin : g_shift
            assign shift_in[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_in[DATA_W-1] = x_bit;

    assign word_done = bus.z_valid_i && (cnt_reg == LAST_CNT);
    assign load_word = word_done && (!data_valid_reg || bus.data_ready_i);

    always_comb begin
        cnt_next        = cnt_reg;
        data_next       = data_reg;
        data_valid_next = data_valid_reg;
        overflow_next   = overflow_reg;
        if (bus.z_valid_i) begin
            cnt_next = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + CNT_W'(1);
        end
        if (load_word) begin
            data_next       = shift_in;
            data_valid_next = 1'b1;
        end else if (data_valid_reg && bus.data_ready_i) begin
            data_valid_next = 1'b0;
        end
        // A full, unaccepted buffer drops the word; alignment is kept by the counter
        if (word_done && !load_word) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg        <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else if (clr_i) begin
            cnt_reg        <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            if (bus.z_valid_i) begin
                shift_reg <= shift_in;
            end
            data_reg       <= data_next;
            data_valid_reg <= data_valid_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign bus.data_o       = data_reg;
    assign bus.data_valid_o = data_valid_reg;
    assign bus.overflow_o   = overflow_reg;
endmodule

// File: doc/msg_deconverter_rx.md
Name: msg_deconverter_rx

Overview:
- Receive-side inverse of the team's Mealy message converter (encoder).
- Encoder rule: z = x XOR s; state s toggles on every x=0; s starts at 0.
- This block recovers x from the encoded serial stream z, deserialises x into DATA_W-bit words, and presents the words on a valid/ready output buffer.
- Sits between the serial link input and the word-level message consumer.

Parameters:
- DATA_W, 8, bits per deserialised word; legal range 2..32.
- CNT_W, $clog2(DATA_W), width of the internal bit counter (derived; do not override).

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- clr_i  input  1  synchronous restart; returns block to reset state except that it does not assert reset
- z_i  input  1  encoded serial bit
- z_valid_i  input  1  z_i is sampled on a clock edge only when this is 1
- x_o  output  1  combinational decoded bit, x_o = z_i XOR s (Mealy); meaningful only while z_valid_i=1
- data_o  output  DATA_W  deserialised word; first received bit lands in data_o[0] (LSB-first)
- data_valid_o  output  1  data_o holds an unconsumed word
- data_ready_i  input  1  consumer accepts data_o on an edge where data_valid_o and data_ready_i are both 1
- overflow_o  output  1  sticky flag: a completed word was dropped

Behaviour:
- Reset (rstn_i=0, async), and clr_i=1 at a clock edge (clr_i has priority over all other inputs):
  - s=0, bit counter=0, shift register=0.
  - data_o=0, data_valid_o=0, overflow_o=0.
- Decoder state s: two-state FSM, S_EVEN (s=0) and S_ODD (s=1).
  - On an edge with z_valid_i=1: x = z_i XOR s; s_next = s XOR (NOT x).
  - With z_valid_i=0, nothing changes: s, counter and shift register all hold.
- Deserialiser, on each edge with z_valid_i=1:
  - x is shifted in at the MSB side, shifting right, so that after DATA_W bits the first bit sits at bit 0.
  - Counter increments and wraps from DATA_W-1 to 0. The bit that causes the wrap completes the word.
- Word completion (same edge that captures the last bit):
  - If data_valid_o=0, or data_ready_i=1 this cycle: load data_o with the completed word (including the last bit) and set data_valid_o=1. Latency is 1 edge: data_valid_o is high in the cycle after the edge sampling the last bit.
  - Otherwise (output full and not accepted): discard the word, keep data_o/data_valid_o unchanged, set overflow_o=1.
  - Decoder state s and the counter continue normally in both cases, so word alignment is preserved.
- Handshake:
  - Accept with no new completion: data_valid_o clears on that edge.
  - Accept and completion on the same edge: data_valid_o stays 1 and data_o takes the new word.
  - data_o is stable while data_valid_o=1 and data_ready_i=0.
- overflow_o clears only on reset or clr_i.
- Partial word at clr_i or reset is discarded; the next valid bit starts a new word with s=0.
- s carries across word boundaries. The decoder is continuous over the stream, matching the encoder, which is not reset per word.

Test Plan:
- DATA_W=8; feed z=1,0,0,1,0,0,1,1 (encoding of 8'hA5) on consecutive edges with z_valid_i=1 and data_ready_i=1 -> x_o per bit 1,0,1,0,0,1,0,1; one cycle after the 8th bit, data_valid_o=1 and data_o=8'hA5; s ends at 0.
- Back-to-back words: z=1×8 (x=8'hFF), then z=0,1,0,1,0,1,0,1 (x=8'h00) -> words 8'hFF then 8'h00; s=0 after each word; no overflow.
- Gapped input: the 8'hA5 stream with z_valid_i=0 inserted for 3 cycles between bits 4 and 5 -> data_o=8'hA5; word completes at the 8th valid edge; no state change during gaps.
- Backpressure: data_ready_i=0 while two words complete -> first word held stable; second dropped; overflow_o=1. Then data_ready_i=1 for one cycle -> data_valid_o=0, overflow_o stays 1.
- Simultaneous accept and completion: first word pending; second word's last bit arrives with data_ready_i=1 -> data_valid_o stays 1; data_o switches to the second word on that edge.
- Mid-word clr_i after 3 bits, then the full 8'hA5 stream -> data_o=8'hA5 (no leftover bits); overflow_o=0. An async rstn_i pulse mid-word gives the same result.
